// File: rtl/fifo_gray_ptr_ctrl.sv
// fifo_gray_ptr_ctrl: one pointer domain of an asynchronous FIFO.
// IS_WRITE=1 builds the write side (flag = full), IS_WRITE=0 the read side
// (flag = empty). The local binary/Gray pointer pair advances on inc when the
// flag is clear; the opposite domain's Gray pointer is brought in through a
// plain SYNC_STAGES-deep flop chain and decoded to binary for flag and level.
// Optional feature: define GRAY_PTR_CTRL_ALMOST_EN to add the registered
// almost output (almost full / almost empty, threshold ALMOST_TH).
module fifo_gray_ptr_ctrl #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int IS_WRITE    = 1,
    parameter int ALMOST_TH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [ADDR_W:0]   remote_ptr,
    output logic [ADDR_W-1:0] adr,
    output logic [ADDR_W:0]   ptr,
    output logic              flag,
    output logic [ADDR_W:0]   level
`ifdef GRAY_PTR_CTRL_ALMOST_EN
    ,
    output logic              almost
`endif
);

    // Reject configurations outside the supported ranges at elaboration time.
    if (ADDR_W < 2 || ADDR_W > 12 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        ALMOST_TH < 0 || ALMOST_TH > (1 << ADDR_W)) begin : g_param_check
        $error("fifo_gray_ptr_ctrl: parameter out of range");
    end

    // Occupancy that means "full" on the write side.
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    // Reset value of flag (and almost): full/almost-full clear, empty set.
    localparam logic            FLAG_RST = (IS_WRITE == 0);

    logic [ADDR_W:0]   bin_q, bin_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              flag_q, flag_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [ADDR_W:0]   sync_q [SYNC_STAGES];
    logic [ADDR_W:0]   sync_d [SYNC_STAGES];
    logic [ADDR_W:0]   rs;
    logic [ADDR_W:0]   rbin;
    logic              fire;

    // Synchroniser chain: pure wiring between stages, nothing combinational.
    always_comb begin
        sync_d[0] = remote_ptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Decode the synchronised Gray pointer: each binary bit is the XOR of
    // all Gray bits at and above it.
    always_comb begin
        rs   = sync_q[SYNC_STAGES-1];
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(rs >> i);
        end
    end

    // Next pointer state; flag and level use the post-fire pointer so a local
    // push/pop is reflected on the same edge, while remote movement is only
    // seen after synchronisation (pessimistic flags).
    always_comb begin
        fire  = inc & ~flag_q;
        bin_d = bin_q + {{ADDR_W{1'b0}}, fire};
        ptr_d = bin_d ^ (bin_d >> 1);
        adr_d = bin_d[ADDR_W-1:0];
        if (IS_WRITE != 0) begin
            level_d = bin_d - rbin;
            flag_d  = (level_d == DEPTH);
        end else begin
            level_d = rbin - bin_d;
            flag_d  = (bin_d == rbin);
        end
    end

    // Pointer, address, flag and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            ptr_q   <= '0;
            adr_q   <= '0;
            flag_q  <= FLAG_RST;
            level_q <= '0;
        end else begin
            bin_q   <= bin_d;
            ptr_q   <= ptr_d;
            adr_q   <= adr_d;
            flag_q  <= flag_d;
            level_q <= level_d;
        end
    end

    assign adr   = adr_q;
    assign ptr   = ptr_q;
    assign flag  = flag_q;
    assign level = level_q;

`ifdef GRAY_PTR_CTRL_ALMOST_EN
    localparam logic [ADDR_W:0] TH_V = (ADDR_W+1)'(ALMOST_TH);

    logic almost_q, almost_d;

    // Almost flag from the same next-state occupancy as flag.
    always_comb begin
        if (IS_WRITE != 0) begin
            almost_d = (level_d >= (DEPTH - TH_V));
        end else begin
            almost_d = (level_d <= TH_V);
        end
    end

    // Almost register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_q <= FLAG_RST;
        end else begin
            almost_q <= almost_d;
        end
    end

    assign almost = almost_q;
`endif

endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// tb_fifo_gray_ptr_ctrl: write-side and read-side instances, with a loopback
// mux that cross-connects their Gray pointers into a complete pointer pair.
// The reference model tracks transfer counts and a delayed view of the
// remote pointer, and derives occupancy/flags with modular arithmetic.
module tb_fifo_gray_ptr_ctrl;

    localparam int AW    = 3;
    localparam int SS    = 2;
    localparam int TH    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int MODV  = 2 * DEPTH;

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk;
    logic          rst;
    logic          wr_inc, rd_inc, lb;
    logic [AW:0]   wr_rem_drv, rd_rem_drv, wr_remote, rd_remote;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [AW:0]   wr_ptr, rd_ptr, wr_level, rd_level;
    logic          wr_flag, rd_flag;
`ifdef GRAY_PTR_CTRL_ALMOST_EN
    logic          wr_almost, rd_almost;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wr_remote = lb ? rd_ptr : wr_rem_drv;
    assign rd_remote = lb ? wr_ptr : rd_rem_drv;

    fifo_gray_ptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .IS_WRITE(1), .ALMOST_TH(TH)) u_wr (
        .clk(clk), .rst(rst), .inc(wr_inc), .remote_ptr(wr_remote),
        .adr(wr_adr), .ptr(wr_ptr), .flag(wr_flag), .level(wr_level)
`ifdef GRAY_PTR_CTRL_ALMOST_EN
        , .almost(wr_almost)
`endif
    );

    fifo_gray_ptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .IS_WRITE(0), .ALMOST_TH(TH)) u_rd (
        .clk(clk), .rst(rst), .inc(rd_inc), .remote_ptr(rd_remote),
        .adr(rd_adr), .ptr(rd_ptr), .flag(rd_flag), .level(rd_level)
`ifdef GRAY_PTR_CTRL_ALMOST_EN
        , .almost(rd_almost)
`endif
    );

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    int m_wcnt, m_rcnt, m_wocc, m_rocc;
    bit m_wflag, m_rflag, m_walm, m_ralm;
    int wq[$];
    int rq[$];

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) % MODV;
    endfunction

    // Decode by search: which count has this Gray code?
    function automatic int gray_dec(input int g);
        for (int b = 0; b < MODV; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_wocc = 0; m_rocc = 0;
        m_wflag = 1'b0; m_rflag = 1'b1; m_walm = 1'b0; m_ralm = 1'b1;
        wq.delete(); rq.delete();
        for (int i = 0; i < SS; i++) begin
            wq.push_back(0);
            rq.push_back(0);
        end
    endtask

    // One clock edge of both sides: wrem/rrem are the remote pointer values
    // present at this edge; the value used now is the one seen SS edges ago.
    task automatic model_edge(input bit wi, input bit ri, input int wrem, input int rrem);
        int used_w, used_r;
        if (wi && !m_wflag) m_wcnt = (m_wcnt + 1) % MODV;
        if (ri && !m_rflag) m_rcnt = (m_rcnt + 1) % MODV;
        used_w = wq.pop_front(); wq.push_back(wrem);
        used_r = rq.pop_front(); rq.push_back(rrem);
        m_wocc  = (m_wcnt - gray_dec(used_w) + MODV) % MODV;
        m_wflag = (m_wocc == DEPTH);
        m_walm  = (m_wocc >= DEPTH - TH);
        m_rocc  = (gray_dec(used_r) - m_rcnt + MODV) % MODV;
        m_rflag = (m_rocc == 0);
        m_ralm  = (m_rocc <= TH);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("wr_ptr",   32'(wr_ptr),   32'(gray_of(m_wcnt)));
        check("wr_adr",   32'(wr_adr),   32'(m_wcnt % DEPTH));
        check("wr_flag",  32'(wr_flag),  32'(m_wflag));
        check("wr_level", 32'(wr_level), 32'(m_wocc));
        check("rd_ptr",   32'(rd_ptr),   32'(gray_of(m_rcnt)));
        check("rd_adr",   32'(rd_adr),   32'(m_rcnt % DEPTH));
        check("rd_flag",  32'(rd_flag),  32'(m_rflag));
        check("rd_level", 32'(rd_level), 32'(m_rocc));
`ifdef GRAY_PTR_CTRL_ALMOST_EN
        check("wr_almost", 32'(wr_almost), 32'(m_walm));
        check("rd_almost", 32'(rd_almost), 32'(m_ralm));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit wi, input bit ri);
        int wrem, rrem;
        wr_inc = wi;
        rd_inc = ri;
        wrem = lb ? gray_of(m_rcnt) : int'(wr_rem_drv);
        rrem = lb ? gray_of(m_wcnt) : int'(rd_rem_drv);
        @(posedge clk);
        #1;
        model_edge(wi, ri, wrem, rrem);
        compare_all();
        wr_inc = 1'b0;
        rd_inc = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        wr_rem_drv = '0;
        rd_rem_drv = '0;
        model_reset();
        #1;
        compare_all();
        check("rst_wr_ptr",   32'(wr_ptr),   32'd0);
        check("rst_wr_level", 32'(wr_level), 32'd0);
        check("rst_wr_flag",  32'(wr_flag),  32'd0);
        check("rst_rd_flag",  32'(rd_flag),  32'd1);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int fires, prev_w, seen;
        bit visited [MODV];

        rst = 1'b0; lb = 1'b0; wr_inc = 1'b0; rd_inc = 1'b0;
        wr_rem_drv = '0; rd_rem_drv = '0;
        #1 rst = 1'b1;
        model_reset();
        #2;
        compare_all();
        check("reset_rd_flag",  32'(rd_flag),  32'd1);
        check("reset_wr_flag",  32'(wr_flag),  32'd0);
        check("reset_wr_level", 32'(wr_level), 32'd0);
        #4 rst = 1'b0;

        // Write side fills with remote pointer at 0.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("full_flag",  32'(wr_flag),  32'd1);
        check("full_ptr",   32'(wr_ptr),   32'b1100);
        check("full_adr",   32'(wr_adr),   32'd0);
        check("full_level", 32'(wr_level), 32'd8);
        step(1'b1, 1'b0);
        check("inc_when_full_ptr",   32'(wr_ptr),   32'b1100);
        check("inc_when_full_level", 32'(wr_level), 32'd8);

        // Remote read pointer advances to 3: full clears after sync latency.
        wr_rem_drv = 4'b0010;
        step(1'b0, 1'b0);
        check("full_hold_1", 32'(wr_flag), 32'd1);
        step(1'b0, 1'b0);
        check("full_hold_2", 32'(wr_flag), 32'd1);
        step(1'b0, 1'b0);
        check("full_clear_3", 32'(wr_flag),  32'd0);
        check("level_after_3", 32'(wr_level), 32'd5);
`ifdef GRAY_PTR_CTRL_ALMOST_EN
        check("wr_almost_lvl5", 32'(wr_almost), 32'd0);
`endif

        // Read side: remote write pointer at 2.
        rd_rem_drv = 4'b0011;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("empty_clear", 32'(rd_flag),  32'd0);
        check("rd_level_2",  32'(rd_level), 32'd2);
`ifdef GRAY_PTR_CTRL_ALMOST_EN
        check("rd_almost_lvl2", 32'(rd_almost), 32'd1);
`endif
        step(1'b0, 1'b1);
        check("pop1_adr", 32'(rd_adr), 32'd1);
        step(1'b0, 1'b1);
        check("pop2_adr",   32'(rd_adr),  32'd2);
        check("pop2_empty", 32'(rd_flag), 32'd1);
        step(1'b0, 1'b1);
        check("pop3_ignored", 32'(rd_adr), 32'd2);

        // Mid-stream asynchronous reset with write level 5.
        pulse_reset();

`ifdef GRAY_PTR_CTRL_ALMOST_EN
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check("wr_almost_lvl6", 32'(wr_almost), 32'd1);
        pulse_reset();
`endif

        // Loopback: 16-transfer stream through both sides.
        lb = 1'b1;
        pulse_reset();
        fires = 0;
        for (int i = 0; i < MODV; i++) visited[i] = 1'b0;
        visited[0] = 1'b1;
        for (int c = 0; c < 100 && fires < 16; c++) begin
            prev_w = m_wcnt;
            step(1'b1, 1'b1);
            if (m_wcnt != prev_w) fires++;
            visited[wr_ptr] = 1'b1;
            check("gray_single_step", 32'($countones(wr_ptr ^ 4'(gray_of(prev_w))) <= 1), 32'd1);
        end
        check("lb_fires", 32'(fires), 32'd16);
        check("lb_wrap_ptr", 32'(wr_ptr), 32'd0);
        check("lb_wrap_adr", 32'(wr_adr), 32'd0);
        seen = 0;
        for (int i = 0; i < MODV; i++) seen += int'(visited[i]);
        check("gray_codes_visited", 32'(seen), 32'd16);

        // Random loopback traffic: fill-biased, drain-biased, balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 120; c++) begin
                bit wi, ri;
                wi = (ph == 0) ? ($urandom_range(0, 3) != 0) :
                     (ph == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
                ri = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                     (ph == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                step(wi, ri);
            end
        end

        // Random independent remote pointers with arbitrary Gray jumps.
        lb = 1'b0;
        pulse_reset();
        for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 3) == 0) wr_rem_drv = 4'(gray_of($urandom_range(0, MODV - 1)));
            if ($urandom_range(0, 3) == 0) rd_rem_drv = 4'(gray_of($urandom_range(0, MODV - 1)));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
